// File: rtl/dispatch_reg_tracker_if.sv
// dispatch_reg_tracker_if
// Groups the dispatch tracker's insert, delete, read, hazard-query and status
// signals. clock and reset are not part of this interface.
//   master : decode/issue side; drives requests and samples the results
//   slave  : the tracker itself
// Signals:
//   ins_valid/ins_ready/ins_rs1/ins_rs2/ins_rW/ins_index : insert channel
//   del_valid/del_index                                   : delete channel
//   rd_index/rd_data/rd_valid                             : registered read port
//   hz_rs1/hz_rs2/hz_rs1_busy/hz_rs2_busy                 : RAW busy query
//   count/full/empty                                      : occupancy status
interface dispatch_reg_tracker_if #(
    parameter int REG_W = 5,
    parameter int IDX_W = 4
);
    logic               ins_valid;
    logic               ins_ready;
    logic [REG_W-1:0]   ins_rs1;
    logic [REG_W-1:0]   ins_rs2;
    logic [REG_W-1:0]   ins_rW;
    logic [IDX_W-1:0]   ins_index;
    logic               del_valid;
    logic [IDX_W-1:0]   del_index;
    logic [IDX_W-1:0]   rd_index;
    logic [3*REG_W-1:0] rd_data;
    logic               rd_valid;
    logic [REG_W-1:0]   hz_rs1;
    logic [REG_W-1:0]   hz_rs2;
    logic               hz_rs1_busy;
    logic               hz_rs2_busy;
    logic [IDX_W:0]     count;
    logic               full;
    logic               empty;

    modport master (
        output ins_valid, ins_rs1, ins_rs2, ins_rW,
        output del_valid, del_index, rd_index, hz_rs1, hz_rs2,
        input  ins_ready, ins_index, rd_data, rd_valid,
        input  hz_rs1_busy, hz_rs2_busy, count, full, empty
    );

    modport slave (
        input  ins_valid, ins_rs1, ins_rs2, ins_rW,
        input  del_valid, del_index, rd_index, hz_rs1, hz_rs2,
        output ins_ready, ins_index, rd_data, rd_valid,
        output hz_rs1_busy, hz_rs2_busy, count, full, empty
    );
endinterface

// File: rtl/dispatch_reg_tracker.sv
// dispatch_reg_tracker
// Holds in-flight instruction register tuples {rs1, rs2, rW}, one per slot.
// Inserts land in the lowest free slot, deletes free a slot, a registered read
// port returns a slot's tuple and valid bit, and a combinational busy check
// compares two source operands against the destinations still in flight.
// Ports:
//   clock : rising-edge clock for all state
//   reset : synchronous, active-high; clears all slots and the read port
//   bus   : dispatch_reg_tracker_if.slave (insert/delete/read/hazard/status)
module dispatch_reg_tracker #(
    parameter int REG_W     = 5,
    parameter int IDX_W     = 4,
    parameter bit IGNORE_X0 = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    dispatch_reg_tracker_if.slave  bus
);
    localparam int             DEPTH     = 1 << IDX_W;
    localparam int             ENT_W     = 3 * REG_W;
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0] valid_q;
    logic [ENT_W-1:0] entry_q [DEPTH];
    logic [IDX_W:0]   count_q;
    logic [ENT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    logic [IDX_W-1:0] free_idx;
    logic             full_w;
    logic             empty_w;
    logic             ins_fire;
    logic             del_eff;
    logic             busy1;
    logic             busy2;

    // Lowest invalid slot; scanning downward lets the lowest match win.
    // Stays 0 when every slot is valid.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign full_w   = (count_q == DEPTH_CNT);
    assign empty_w  = (count_q == '0);
    assign ins_fire = bus.ins_valid && !full_w;
    assign del_eff  = bus.del_valid && valid_q[bus.del_index];

    // Busy check over slots valid at the start of the cycle: a same-cycle
    // insert is not yet visible and a same-cycle delete still is.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && entry_q[i][REG_W-1:0] == bus.hz_rs1) busy1 = 1'b1;
            if (valid_q[i] && entry_q[i][REG_W-1:0] == bus.hz_rs2) busy2 = 1'b1;
        end
        if (IGNORE_X0 && bus.hz_rs1 == '0) busy1 = 1'b0;
        if (IGNORE_X0 && bus.hz_rs2 == '0) busy2 = 1'b0;
    end

    // free_idx only ever names an invalid slot and a delete only acts on a
    // valid one, so a same-cycle insert and delete never touch the same slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            rd_data_q  <= entry_q[bus.rd_index];
            rd_valid_q <= valid_q[bus.rd_index];
            if (del_eff) valid_q[bus.del_index] <= 1'b0;
            if (ins_fire) begin
                valid_q[free_idx] <= 1'b1;
                entry_q[free_idx] <= {bus.ins_rs1, bus.ins_rs2, bus.ins_rW};
            end
            case ({ins_fire, del_eff})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.ins_ready   = !full_w;
    assign bus.ins_index   = free_idx;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.hz_rs1_busy = busy1;
    assign bus.hz_rs2_busy = busy2;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
endmodule

// File: doc/dispatch_reg_tracker.md
Name: dispatch_reg_tracker

Overview:
Parametrised successor to the dispatch register storage. Holds in-flight instruction register tuples {rs1, rs2, rW}, one per slot. Allocates the lowest free slot on insert, frees slots on delete, and provides a registered read port, occupancy and full/empty status. Adds a combinational busy-register (RAW) check so dispatch can test source operands against destinations still in flight. Sits between decode and issue in the dispatch stage.

Parameters:
REG_W, 5, register-address width
IDX_W, 4, slot-index width; DEPTH = 2**IDX_W slots
IGNORE_X0, 1, when 1, register 0 is never reported busy

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
ins_valid  in  1  insert request
ins_ready  out  1  insert accepted this cycle (= !full)
ins_rs1  in  REG_W  source 1 of inserted entry
ins_rs2  in  REG_W  source 2 of inserted entry
ins_rW  in  REG_W  destination of inserted entry
ins_index  out  IDX_W  slot the insert lands in (lowest free), combinational
del_valid  in  1  delete request
del_index  in  IDX_W  slot to free
rd_index  in  IDX_W  read address
rd_data  out  3*REG_W  registered {rs1,rs2,rW} of rd_index
rd_valid  out  1  registered valid bit of rd_index
hz_rs1  in  REG_W  hazard query operand 1
hz_rs2  in  REG_W  hazard query operand 2
hz_rs1_busy  out  1  some valid slot has rW == hz_rs1
hz_rs2_busy  out  1  some valid slot has rW == hz_rs2
count  out  IDX_W+1  number of valid slots
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (sync, active-high): all valid bits 0, slot payloads 0, rd_data 0, rd_valid 0, count 0. Therefore empty=1, full=0, ins_ready=1, ins_index=0, busy outputs 0. Reset overrides same-cycle insert and delete. Reset mid-operation discards all entries.
- Allocation: ins_index is a priority encode of the lowest-numbered invalid slot, based on state at the start of the cycle. It is 0 when full (don't-care).
- Insert: fires when ins_valid && ins_ready. On the edge, the slot is written with {ins_rs1,ins_rs2,ins_rW} and marked valid. An insert while full is dropped, with no state change.
- Delete: when del_valid and the slot is valid, it is cleared on the edge; the payload is retained but ignored. Delete of an invalid slot is a no-op and count is unchanged.
- Simultaneous insert and delete: both take effect. Allocation uses pre-edge state, so a slot being deleted this cycle is not reused until the next cycle; there is no index conflict. count changes by (ins fire) - (del effective), so +1-1 = unchanged. If full, a same-cycle delete does not make ins_ready high in that cycle.
- Read: 1-cycle latency. rd_data and rd_valid are sampled from post-edge-prior state, i.e. the values held before this edge's writes. An entry inserted at edge N is readable at rd_data after edge N+1.
- Hazard check: combinational, over slots valid at the start of the cycle. The same-cycle insert is not visible; the same-cycle delete is still visible. With IGNORE_X0=1, a query for register 0 is never busy.
- count saturates structurally at 0..DEPTH. full and empty are derived from count combinationally.

Test Plan:
- Reset then insert {rs1=0x0A, rs2=0x15, rW=0x1C} -> ins_index=0 at accept. Next cycle count=1, empty=0. With rd_index=0, one cycle later rd_data=0x2ABC (0x0A,0x15,0x1C packed), rd_valid=1.
- Insert 16 entries with rW=i+1 on consecutive cycles -> ins_index 0..15, full=1, count=16, ins_ready=0. A 17th insert is dropped and count stays 16.
- From full, delete slot 5 -> count=15 next cycle. A following insert lands at ins_index=5. Deleting already-invalid slot 5 twice leaves count unchanged.
- Same cycle: delete slot 0 and insert with 3 slots valid -> insert goes to slot 3, count stays 3, slot 0 is free and allocated by the next insert.
- Slot holds rW=0x07 -> hz_rs1=7 gives busy=1 same cycle. After deleting it, busy=0 one cycle later. With rW=0 inserted, hz_rs2=0 gives busy=0 (IGNORE_X0=1).
- Assert reset while 10 entries are valid and insert is active -> next cycle count=0, empty=1, rd_valid=0, all busy=0.
